song_recorder: RTL and testbench

//  Captures notes played on the 7-key keyboard in record mode into an on-chip song RAM as
//  {note, duration} entries. Exposes a registered read port so auto_player can play the take

---
 rtl/song_recorder_pkg.sv | 34 +++
 rtl/song_recorder_key_debouncer.sv | 39 +++
 rtl/song_recorder.sv | 179 +++++++++++++++++
 tb/tb_song_recorder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/song_recorder_pkg.sv
// Shared constants, FSM state codes and the key-to-note encoder for the song recorder.
// Optional feature macro used by the top: REC_REST_TRIM_EN.
package song_recorder_pkg;

  localparam int KEY_W   = 7;
  localparam int PITCH_W = 2;
  localparam int CODE_W  = 3;
  localparam int NOTE_W  = PITCH_W + CODE_W;

  typedef logic [NOTE_W-1:0] note_t;

  localparam logic [2:0]  REC_MODE  = 3'b101;
  localparam note_t       NOTE_REST = 5'b00000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_REC  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Lowest pressed key wins; a rest is always the all-zero note regardless of pitch.
  function automatic note_t note_encode(input logic [KEY_W-1:0] key,
                                        input logic [PITCH_W-1:0] pitch);
    logic [CODE_W-1:0]  code;
    logic [PITCH_W-1:0] oct;
    code = '0;
    for (int i = KEY_W - 1; i >= 0; i--) begin
      if (key[i]) code = CODE_W'(i + 1);
    end
    oct = (pitch == 2'b11) ? 2'b00 : pitch;
    if (code == '0) return NOTE_REST;
    return {oct, code};
  endfunction

endpackage

// File: rtl/song_recorder_key_debouncer.sv
// Debounces the encoded {pitch, key_code} note: the output follows only after the
// same note has been sampled DEBOUNCE_CYCLES consecutive clocks.
module song_recorder_key_debouncer
  import song_recorder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_W-1:0]   key,
  input  logic [PITCH_W-1:0] pitch,
  output note_t              note
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  note_t            raw_note;
  note_t            cand;
  logic [CNT_W-1:0] cnt;

  assign raw_note = note_encode(key, pitch);

  // NOTE: sequential state uses <= so every register samples pre-edge values; = here would chain updates within one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand <= NOTE_REST;
      cnt  <= '0;
      note <= NOTE_REST;
    end else if (raw_note != cand) begin
      cand <= raw_note;
      cnt  <= CNT_W'(1);
    end else if (cnt >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      note <= cand;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/song_recorder.sv
// Records debounced keyboard notes as {note, duration} entries into a song RAM with a
// registered read port for playback. Define REC_REST_TRIM_EN to drop a trailing rest on stop.
module song_recorder
  import song_recorder_pkg::*;
#(
  parameter int  TICK_CYCLES     = 6_250_000,
  parameter int  DEBOUNCE_CYCLES = 1_000_000,
  parameter int  DEPTH           = 256,
  parameter int  DUR_W           = 6,
  localparam int ADDR_W          = $clog2(DEPTH),
  localparam int ENTRY_W         = NOTE_W + DUR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         mode,
  input  logic [KEY_W-1:0]   key,
  input  logic [PITCH_W-1:0] pitch,
  input  logic               rec_start,
  input  logic               rec_stop,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [ADDR_W:0]    length,
  output logic               recording,
  output logic               full
);

  localparam int               TICK_W  = $clog2(TICK_CYCLES + 1);
  localparam logic [DUR_W-1:0] DUR_MAX = {DUR_W{1'b1}};

  note_t deb_note;

  song_recorder_key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk  (clk),
    .rst  (rst),
    .key  (key),
    .pitch(pitch),
    .note (deb_note)
  );

  logic [1:0]         state, state_d;
  logic [ADDR_W:0]    wr_ptr, wr_ptr_d;
  logic [ADDR_W:0]    length_d;
  logic               full_d;
  note_t              cur_note, cur_note_d;
  logic [DUR_W-1:0]   dur, dur_d, close_dur;
  logic [TICK_W-1:0]  tick_ctr, tick_ctr_d;
  logic               tick, stop_req, note_change;
  logic               close_keep, stop_keep;
  logic               wr_en;
  logic [ENTRY_W-1:0] wr_data;

  assign tick        = (tick_ctr == TICK_W'(TICK_CYCLES - 1));
  assign stop_req    = rec_stop || (mode != REC_MODE);
  assign note_change = (deb_note != cur_note);
  // A tick landing on the closing cycle still counts toward the entry, capped at DUR_MAX.
  assign close_dur   = (tick && dur != DUR_MAX) ? dur + DUR_W'(1) : dur;
  assign close_keep  = (close_dur != '0);

`ifdef REC_REST_TRIM_EN
  assign stop_keep = close_keep && (cur_note != NOTE_REST);
`else
  assign stop_keep = close_keep;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state;
    wr_ptr_d   = wr_ptr;
    length_d   = length;
    full_d     = full;
    cur_note_d = cur_note;
    dur_d      = dur;
    tick_ctr_d = tick_ctr;
    wr_en      = 1'b0;
    wr_data    = {cur_note, close_dur};

    case (state)
      ST_IDLE: begin
        if (rec_start && !rec_stop && mode == REC_MODE) begin
          state_d  = ST_ARM;
          wr_ptr_d = '0;
          full_d   = 1'b0;
        end
      end
      ST_ARM: begin
        if (stop_req) begin
          length_d = '0;
          state_d  = ST_IDLE;
        end else if (deb_note != NOTE_REST) begin
          state_d    = ST_REC;
          cur_note_d = deb_note;
          dur_d      = '0;
          tick_ctr_d = '0;
        end
      end
      ST_REC: begin
        if (stop_req) begin
          wr_en    = stop_keep;
          length_d = wr_ptr;
          state_d  = ST_IDLE;
        end else if (note_change) begin
          wr_en      = close_keep;
          cur_note_d = deb_note;
          dur_d      = '0;
          tick_ctr_d = '0;
        end else if (tick) begin
          tick_ctr_d = '0;
          if (dur == DUR_MAX) begin
            // Saturated: emit a full-length entry and keep timing the same note.
            wr_en = 1'b1;
            dur_d = '0;
          end else begin
            dur_d = dur + DUR_W'(1);
          end
        end else begin
          tick_ctr_d = tick_ctr + TICK_W'(1);
        end
      end
      ST_DONE: begin
        if (rec_start || mode != REC_MODE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_en) begin
      wr_ptr_d = wr_ptr + (ADDR_W+1)'(1);
      if (wr_ptr == (ADDR_W+1)'(DEPTH - 1)) begin
        full_d   = 1'b1;
        length_d = (ADDR_W+1)'(DEPTH);
        state_d  = ST_DONE;
      end else if (state == ST_REC && stop_req) begin
        length_d = wr_ptr + (ADDR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      length   <= '0;
      full     <= 1'b0;
      cur_note <= NOTE_REST;
      dur      <= '0;
      tick_ctr <= '0;
    end else begin
      state    <= state_d;
      wr_ptr   <= wr_ptr_d;
      length   <= length_d;
      full     <= full_d;
      cur_note <= cur_note_d;
      dur      <= dur_d;
      tick_ctr <= tick_ctr_d;
    end
  end

  assign recording = (state == ST_ARM) || (state == ST_REC);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // NOTE: the song RAM has no reset so it maps onto block RAM; length=0 already hides stale entries.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

  // Addresses at or past the committed length read as the end-of-song marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if ({1'b0, rd_addr} < length) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_song_recorder.sv
// Directed bench for song_recorder with small timing parameters and hand-computed entries.
module tb_song_recorder;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mode;
  logic [6:0] key;
  logic [1:0] pitch;
  logic       rec_start, rec_stop;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic [2:0] length;
  logic       recording, full;

  int n_cmp = 0;
  int n_bad = 0;

  song_recorder #(
    .TICK_CYCLES    (4),
    .DEBOUNCE_CYCLES(2),
    .DEPTH          (4),
    .DUR_W          (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .key      (key),
    .pitch    (pitch),
    .rec_start(rec_start),
    .rec_stop (rec_stop),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .length   (length),
    .recording(recording),
    .full     (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    rec_start = 1'b1;
    step(1);
    rec_start = 1'b0;
  endtask

  task automatic pulse_stop();
    rec_stop = 1'b1;
    step(1);
    rec_stop = 1'b0;
  endtask

  task automatic check_entry(input string tag, input logic [1:0] addr, input logic [7:0] exp);
    rd_addr = addr;
    step(1);
    check(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  initial begin
    rst = 1'b1; mode = 3'b101; key = '0; pitch = 2'b00;
    rec_start = 1'b0; rec_stop = 1'b0; rd_addr = '0;
    step(3);
    rst = 1'b0;

    // 1: reset state
    check_entry("reset_rd_data", 2'd0, 8'h00);
    check("reset_length", {29'd0, length}, 32'd0);
    check("reset_recording", {31'd0, recording}, 32'd0);
    check("reset_full", {31'd0, full}, 32'd0);

    // 2: do/mid held 12 clk -> {00001,3}
    pulse_start();
    check("arm_recording", {31'd0, recording}, 32'd1);
    key = 7'b0000001;
    step(12);
    key = '0;
    step(3);
    pulse_stop();
    check("t2_length", {29'd0, length}, 32'd1);
    check("t2_recording", {31'd0, recording}, 32'd0);
    check_entry("t2_entry0", 2'd0, 8'h0B);
    check_entry("t2_past_end", 2'd1, 8'h00);

    // 3: mi/high held 40 clk -> saturated {10011,7} then {10011,1}
    step(4);
    pulse_start();
    key = 7'b0000100; pitch = 2'b10;
    step(40);
    pulse_stop();
    key = '0; pitch = 2'b00;
    check("t3_length", {29'd0, length}, 32'd2);
    check_entry("t3_entry0", 2'd0, 8'h9F);
    check_entry("t3_entry1", 2'd1, 8'h99);

    // 4: five notes of 8 clk fill the 4-entry RAM
    step(4);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      key = 7'(1 << i);
      step(8);
    end
    key = '0;
    check("t4_full", {31'd0, full}, 32'd1);
    check("t4_length", {29'd0, length}, 32'd4);
    check("t4_recording", {31'd0, recording}, 32'd0);
    check_entry("t4_entry0", 2'd0, 8'h0A);
    check_entry("t4_entry1", 2'd1, 8'h12);
    check_entry("t4_entry2", 2'd2, 8'h1A);
    check_entry("t4_entry3", 2'd3, 8'h22);
    pulse_start();
    check("t4_done_exit_full_held", {31'd0, full}, 32'd1);
    check("t4_done_exit_idle", {31'd0, recording}, 32'd0);

    // 5: do 8 clk then a trailing rest of dur 2
    step(4);
    pulse_start();
    check("t5_full_cleared", {31'd0, full}, 32'd0);
    key = 7'b0000001;
    step(8);
    key = '0;
    step(11);
    pulse_stop();
    check_entry("t5_entry0", 2'd0, 8'h0A);
`ifdef REC_REST_TRIM_EN
    check("t5_length", {29'd0, length}, 32'd1);
    check_entry("t5_entry1", 2'd1, 8'h00);
`else
    check("t5_length", {29'd0, length}, 32'd2);
    check_entry("t5_entry1", 2'd1, 8'h02);
`endif

    // 6a: start+stop together in IDLE -> stays idle, length untouched
    rec_start = 1'b1; rec_stop = 1'b1;
    step(1);
    rec_start = 1'b0; rec_stop = 1'b0;
    check("t6_idle_both", {31'd0, recording}, 32'd0);
`ifdef REC_REST_TRIM_EN
    check("t6_idle_length", {29'd0, length}, 32'd1);
`else
    check("t6_idle_length", {29'd0, length}, 32'd2);
`endif

    // 6b: 1-clk glitch while armed is not a note; stop in ARM clears length
    pulse_start();
    key = 7'b0000010;
    step(1);
    key = '0;
    step(4);
    check("t6_glitch_still_arm", {31'd0, recording}, 32'd1);
    pulse_stop();
    check("t6_arm_stop_length", {29'd0, length}, 32'd0);

    // 6c: glitch inside a held note, then start+stop together in REC
    step(2);
    pulse_start();
    key = 7'b0000001;
    step(3);
    key = 7'b0000010;
    step(1);
    key = 7'b0000001;
    step(4);
    rec_start = 1'b1; rec_stop = 1'b1;
    step(1);
    rec_start = 1'b0; rec_stop = 1'b0;
    key = '0;
    check("t6_rec_both_idle", {31'd0, recording}, 32'd0);
    check("t6_rec_both_length", {29'd0, length}, 32'd1);
    check_entry("t6_entry0", 2'd0, 8'h09);
    check_entry("t6_stale_hidden", 2'd1, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
